// File: rtl/layer_compositor_pipe_pkg.sv
// ============================================================================
// Module      : layer_compositor_pipe_pkg
// Description : Shared constants and helpers for the layer compositor.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package layer_compositor_pipe_pkg;

  localparam int CH_W_DEF = 4;

  localparam logic [1:0] MODE_CHANNEL_KEY = 2'd0;
  localparam logic [1:0] MODE_PIXEL_KEY   = 2'd1;
  localparam logic [1:0] MODE_BLEND       = 2'd2;

  // Bit offset of channel ch (0=B, 1=G, 2=R) inside a packed RGB pixel.
  function automatic int ch_lsb(input int ch, input int ch_w);
    return ch * ch_w;
  endfunction

endpackage

`default_nettype wire

// File: rtl/layer_opacity_mask.sv
// ============================================================================
// Module      : layer_opacity_mask
// Description : Per-channel opacity of one object layer for the active mode.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module layer_opacity_mask
  import layer_compositor_pipe_pkg::*;
#(
  parameter  int CH_W  = CH_W_DEF,
  localparam int PIX_W = 3 * CH_W
) (
  input  logic [PIX_W-1:0] pix,
  input  logic [1:0]       mode,
  input  logic [PIX_W-1:0] key,
  input  logic             en,
  output logic [2:0]       mask
);

  logic       w_key_mode;
  logic       w_pix_opq;
  logic [2:0] w_ch_opq;

  // Reserved mode 3 falls through to channel keying.
  assign w_key_mode = (mode == MODE_PIXEL_KEY) || (mode == MODE_BLEND);
  assign w_pix_opq  = (pix != key);

  genvar c;
  generate
    for (c = 0; c < 3; c++) begin : g_ch
      assign w_ch_opq[c] = |pix[ch_lsb(c, CH_W) +: CH_W];
    end
  endgenerate

  assign mask = !en       ? 3'b000 :
                w_key_mode ? {3{w_pix_opq}} :
                             w_ch_opq;

endmodule

`default_nettype wire

// File: rtl/layer_compositor_pipe.sv
// ============================================================================
// Module      : layer_compositor_pipe
// Description : Two-stage compositor of LAYERS object planes over a background.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module layer_compositor_pipe
  import layer_compositor_pipe_pkg::*;
#(
  parameter  int CH_W   = CH_W_DEF,
  parameter  int LAYERS = 3,
  localparam int PIX_W  = 3 * CH_W
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [1:0]              cfg_mode,
  input  logic [LAYERS-1:0]       cfg_layer_en,
  input  logic [PIX_W-1:0]        cfg_key,
  input  logic                    in_valid,
  input  logic                    in_hs,
  input  logic                    in_vs,
  input  logic [PIX_W-1:0]        in_bg,
  input  logic [LAYERS*PIX_W-1:0] in_layers,
  output logic                    out_valid,
  output logic                    out_hs,
  output logic                    out_vs,
  output logic [PIX_W-1:0]        out_pix
);

  logic [1:0]              r_sh_mode;
  logic [LAYERS-1:0]       r_sh_en;
  logic [PIX_W-1:0]        r_sh_key;

  logic                    r_s1_valid;
  logic                    r_s1_hs;
  logic                    r_s1_vs;
  logic                    r_s1_blend;
  logic [PIX_W-1:0]        r_s1_bg;
  logic [LAYERS*PIX_W-1:0] r_s1_layers;
  logic [3*LAYERS-1:0]     r_s1_mask;

  logic [3*LAYERS-1:0]     w_mask;
  logic                    w_vs_rise;
  logic [PIX_W-1:0]        w_pix;

  // r_s1_vs doubles as the registered in_vs used for edge detection.
  assign w_vs_rise = in_vs && !r_s1_vs;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sh_mode <= MODE_CHANNEL_KEY;
      r_sh_en   <= '1;
      r_sh_key  <= '0;
    end else if (w_vs_rise) begin
      r_sh_mode <= cfg_mode;
      r_sh_en   <= cfg_layer_en;
      r_sh_key  <= cfg_key;
    end
  end

  genvar k;
  generate
    for (k = 0; k < LAYERS; k++) begin : g_layer
      layer_opacity_mask #(
        .CH_W (CH_W)
      ) u_mask (
        .pix  (in_layers[k*PIX_W +: PIX_W]),
        .mode (r_sh_mode),
        .key  (r_sh_key),
        .en   (r_sh_en[k]),
        .mask (w_mask[3*k +: 3])
      );
    end
  endgenerate

  // Stage 1: capture pixel data with the mask computed from the current shadow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid  <= 1'b0;
      r_s1_hs     <= 1'b0;
      r_s1_vs     <= 1'b0;
      r_s1_blend  <= 1'b0;
      r_s1_bg     <= '0;
      r_s1_layers <= '0;
      r_s1_mask   <= '0;
    end else begin
      r_s1_valid  <= in_valid;
      r_s1_hs     <= in_hs;
      r_s1_vs     <= in_vs;
      r_s1_blend  <= (r_sh_mode == MODE_BLEND);
      r_s1_bg     <= in_bg;
      r_s1_layers <= in_layers;
      r_s1_mask   <= w_mask;
    end
  end

  genvar c;
  generate
    for (c = 0; c < 3; c++) begin : g_ch
      logic [CH_W-1:0] w_bg_ch;
      logic [CH_W-1:0] w_win;
      logic            w_any;
      logic [CH_W:0]   w_sum;

      assign w_bg_ch = r_s1_bg[ch_lsb(c, CH_W) +: CH_W];

      // Ascending scan so the highest-index opaque layer is the last to win.
      always_comb begin
        w_win = w_bg_ch;
        w_any = 1'b0;
        for (int i = 0; i < LAYERS; i++) begin
          if (r_s1_mask[3*i + c]) begin
            w_win = r_s1_layers[i*PIX_W + ch_lsb(c, CH_W) +: CH_W];
            w_any = 1'b1;
          end
        end
      end

      assign w_sum = {1'b0, w_win} + {1'b0, w_bg_ch};
      assign w_pix[ch_lsb(c, CH_W) +: CH_W] =
        (r_s1_blend && w_any) ? CH_W'(w_sum >> 1) : w_win;
    end
  endgenerate

  // Stage 2: output register, pixel forced to black during blanking.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_hs    <= 1'b0;
      out_vs    <= 1'b0;
      out_pix   <= '0;
    end else begin
      out_valid <= r_s1_valid;
      out_hs    <= r_s1_hs;
      out_vs    <= r_s1_vs;
      out_pix   <= r_s1_valid ? w_pix : '0;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_layer_compositor_pipe.sv
// ============================================================================
// Module      : tb_layer_compositor_pipe
// Description : Self-checking bench with vector table, corner sequences and
//               randomized traffic against a behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_layer_compositor_pipe;

  localparam int CH_W   = 4;
  localparam int LAYERS = 3;
  localparam int PIX_W  = 3 * CH_W;

  logic                    clk = 1'b0;
  logic                    rst_n = 1'b1;
  logic [1:0]              cfg_mode = '0;
  logic [LAYERS-1:0]       cfg_layer_en = '1;
  logic [PIX_W-1:0]        cfg_key = '0;
  logic                    in_valid = 1'b0;
  logic                    in_hs = 1'b0;
  logic                    in_vs = 1'b0;
  logic [PIX_W-1:0]        in_bg = '0;
  logic [LAYERS*PIX_W-1:0] in_layers = '0;
  logic                    out_valid;
  logic                    out_hs;
  logic                    out_vs;
  logic [PIX_W-1:0]        out_pix;

  layer_compositor_pipe #(
    .CH_W   (CH_W),
    .LAYERS (LAYERS)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .cfg_mode     (cfg_mode),
    .cfg_layer_en (cfg_layer_en),
    .cfg_key      (cfg_key),
    .in_valid     (in_valid),
    .in_hs        (in_hs),
    .in_vs        (in_vs),
    .in_bg        (in_bg),
    .in_layers    (in_layers),
    .out_valid    (out_valid),
    .out_hs       (out_hs),
    .out_vs       (out_vs),
    .out_pix      (out_pix)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model state: config the design should currently be applying.
  logic [1:0]        m_mode;
  logic [LAYERS-1:0] m_en;
  logic [PIX_W-1:0]  m_key;
  logic              m_prev_vs;

  logic [PIX_W+2:0] exp_q[$];
  string            name_q[$];

  function automatic logic [PIX_W-1:0] model_pix(
    input logic [1:0] mode, input logic [LAYERS-1:0] en,
    input logic [PIX_W-1:0] key, input logic [PIX_W-1:0] bg,
    input logic [LAYERS*PIX_W-1:0] lay);
    logic [PIX_W-1:0] res;
    int bgc, win, lc;
    bit any, opq;
    logic [PIX_W-1:0] lp;
    res = '0;
    for (int c = 0; c < 3; c++) begin
      bgc = int'((bg >> (CH_W*c)) & 12'hF);
      win = bgc;
      any = 0;
      for (int k = 0; k < LAYERS; k++) begin
        lp = lay[k*PIX_W +: PIX_W];
        lc = int'((lp >> (CH_W*c)) & 12'hF);
        if (mode == 2'd1 || mode == 2'd2) opq = (lp != key);
        else                              opq = (lc != 0);
        if (en[k] && opq) begin
          win = lc;
          any = 1;
        end
      end
      if (mode == 2'd2 && any) win = (win + bgc) / 2;
      res = res | PIX_W'(win << (CH_W*c));
    end
    return res;
  endfunction

  task automatic step(input logic v, input logic hs, input logic vs,
                      input logic [PIX_W-1:0] bg, input logic [LAYERS*PIX_W-1:0] lay,
                      input bit use_exp, input logic [PIX_W-1:0] exp_pix, input string name);
    logic [PIX_W+2:0] e;
    logic [PIX_W-1:0] p;
    string n;
    in_valid  = v;
    in_hs     = hs;
    in_vs     = vs;
    in_bg     = bg;
    in_layers = lay;
    p = use_exp ? exp_pix : model_pix(m_mode, m_en, m_key, bg, lay);
    if (!v) p = '0;
    exp_q.push_back({v, hs, vs, p});
    name_q.push_back(name);
    if (vs && !m_prev_vs) begin
      m_mode = cfg_mode;
      m_en   = cfg_layer_en;
      m_key  = cfg_key;
    end
    m_prev_vs = vs;
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    n = name_q.pop_front();
    checks++;
    if ({out_valid, out_hs, out_vs, out_pix} !== e) begin
      errors++;
      $display("FAIL %s: got v=%b hs=%b vs=%b pix=%h, expected v=%b hs=%b vs=%b pix=%h",
               n, out_valid, out_hs, out_vs, out_pix,
               e[PIX_W+2], e[PIX_W+1], e[PIX_W], e[PIX_W-1:0]);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    in_valid = 1'b0; in_hs = 1'b0; in_vs = 1'b0; in_bg = '0; in_layers = '0;
    #1;
    checks++;
    if ({out_valid, out_hs, out_vs, out_pix} !== '0) begin
      errors++;
      $display("FAIL rst_async: got v=%b hs=%b vs=%b pix=%h, expected all zero",
               out_valid, out_hs, out_vs, out_pix);
    end
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    m_mode = 2'd0; m_en = '1; m_key = '0; m_prev_vs = 1'b0;
    exp_q.delete();
    name_q.delete();
    exp_q.push_back('0);
    name_q.push_back("post_rst");
  endtask

  task automatic set_cfg(input logic [1:0] mode, input logic [LAYERS-1:0] en,
                         input logic [PIX_W-1:0] key);
    cfg_mode = mode; cfg_layer_en = en; cfg_key = key;
    step(1'b0, 1'b0, 1'b0, '0, '0, 1'b0, '0, "cfg_pre");
    step(1'b0, 1'b0, 1'b1, '0, '0, 1'b0, '0, "cfg_vs");
    step(1'b0, 1'b0, 1'b0, '0, '0, 1'b0, '0, "cfg_post");
  endtask

  function automatic logic [PIX_W-1:0] rnd_pix();
    logic [PIX_W-1:0] p;
    case ($urandom_range(0, 3))
      0:       p = 12'h000;
      1:       p = 12'hF0F;
      default: p = PIX_W'($urandom);
    endcase
    return p;
  endfunction

  task automatic random_run(input int n);
    logic vs_state;
    vs_state = 1'b0;
    for (int i = 0; i < n; i++) begin
      cfg_mode     = 2'($urandom_range(0, 3));
      cfg_layer_en = LAYERS'($urandom);
      cfg_key      = $urandom_range(0, 1) ? 12'h000 : 12'hF0F;
      if ($urandom_range(0, 11) == 0) vs_state = ~vs_state;
      step(1'($urandom_range(0, 3) != 0), 1'($urandom), vs_state,
           PIX_W'($urandom), {rnd_pix(), rnd_pix(), rnd_pix()}, 1'b0, '0, "random");
    end
  endtask

  typedef struct {
    logic [1:0]              mode;
    logic [LAYERS-1:0]       en;
    logic [PIX_W-1:0]        key;
    logic [PIX_W-1:0]        bg;
    logic [LAYERS*PIX_W-1:0] lay;
    logic [PIX_W-1:0]        exp_pix;
  } vec_t;

  vec_t vec[9];

  localparam logic [LAYERS*PIX_W-1:0] FS_LAY = {12'h000, 12'h000, 12'hF80};

  initial begin
    // Layers packed {layer2, layer1, layer0}.
    vec[0] = '{2'd0, 3'b111, 12'h000, 12'h123, {12'h000, 12'h000, 12'h400}, 12'h423};
    vec[1] = '{2'd1, 3'b111, 12'h000, 12'h00F, {12'h000, 12'h0F0, 12'hF00}, 12'h0F0};
    vec[2] = '{2'd1, 3'b101, 12'h000, 12'h00F, {12'h000, 12'h0F0, 12'hF00}, 12'hF00};
    vec[3] = '{2'd1, 3'b111, 12'hF0F, 12'h00F, {12'hF0F, 12'h0F0, 12'hF0F}, 12'h0F0};
    vec[4] = '{2'd2, 3'b111, 12'h000, 12'h08F, {12'h000, 12'h000, 12'hF80}, 12'h787};
    vec[5] = '{2'd1, 3'b000, 12'h000, 12'hABC, {12'h111, 12'h222, 12'h333}, 12'hABC};
    vec[6] = '{2'd3, 3'b111, 12'h000, 12'h123, {12'h000, 12'h000, 12'h400}, 12'h423};
    vec[7] = '{2'd2, 3'b111, 12'h555, 12'h9AB, {12'h555, 12'h555, 12'h555}, 12'h9AB};
    vec[8] = '{2'd2, 3'b111, 12'h000, 12'hFFF, {12'hFFF, 12'h000, 12'h000}, 12'hFFF};

    do_reset();
    random_run(150);

    // Mid-stream reset, then first pixel through the default config.
    do_reset();
    step(1'b1, 1'b0, 1'b0, 12'h123, {12'h000, 12'h000, 12'h400}, 1'b1, 12'h423, "rst_latency");
    step(1'b0, 1'b0, 1'b0, '0, '0, 1'b0, '0, "rst_flush");

    for (int i = 0; i < 9; i++) begin
      set_cfg(vec[i].mode, vec[i].en, vec[i].key);
      step(1'b1, 1'b1, 1'b0, vec[i].bg, vec[i].lay, 1'b1, vec[i].exp_pix,
           $sformatf("vec%0d", i));
    end

    // Mode change mid-line must wait for the next vs rise.
    set_cfg(2'd0, 3'b111, 12'h000);
    step(1'b1, 1'b0, 1'b0, 12'h08F, FS_LAY, 1'b1, 12'hF8F, "fs_pre");
    cfg_mode = 2'd2;
    step(1'b1, 1'b0, 1'b0, 12'h08F, FS_LAY, 1'b1, 12'hF8F, "fs_mid0");
    step(1'b1, 1'b1, 1'b0, 12'h08F, FS_LAY, 1'b1, 12'hF8F, "fs_mid1");
    step(1'b1, 1'b0, 1'b1, 12'h08F, FS_LAY, 1'b1, 12'hF8F, "fs_rise_old");
    step(1'b1, 1'b0, 1'b1, 12'h08F, FS_LAY, 1'b1, 12'h787, "fs_new");
    step(1'b1, 1'b0, 1'b0, 12'h08F, FS_LAY, 1'b1, 12'h787, "fs_hold");

    // Blanking with live pixel data and toggling syncs.
    for (int i = 0; i < 8; i++) begin
      step(1'b0, 1'(i & 1), 1'((i >> 1) & 1), 12'hABC, {12'h123, 12'h456, 12'h789},
           1'b1, 12'h000, "blank");
    end

    random_run(300);
    step(1'b0, 1'b0, 1'b0, '0, '0, 1'b0, '0, "drain");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, expected finish before 200000");
    $fatal(1);
  end

endmodule

`default_nettype wire
